// File: rtl/trigger_link_pkg.sv
// Constants shared by the trigger link transmitter and receiver:
// control K-bytes, frame geometry and the receiver alignment states.
package trigger_link_pkg;

    localparam logic [7:0]  K_NORMAL     = 8'hBC;
    localparam logic [7:0]  K_BC0        = 8'h3C;
    localparam logic [7:0]  K_OVF        = 8'h7C;
    localparam logic [7:0]  K_BC0_OVF    = 8'hFC;
    localparam logic [1:0]  CHARISK_CTRL = 2'b10;

    localparam int unsigned FRAME_WORDS  = 4;
    localparam int unsigned CLUSTER_W    = 14;
    localparam int unsigned N_CLUSTERS   = 4;
    localparam int unsigned FRAME_BITS   = N_CLUSTERS * CLUSTER_W;
    localparam logic [1:0]  LAST_WORD    = 2'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == K_NORMAL) || (b == K_BC0) || (b == K_OVF) || (b == K_BC0_OVF);
    endfunction

    function automatic logic ctrl_bc0(input logic [7:0] b);
        return (b == K_BC0) || (b == K_BC0_OVF);
    endfunction

    function automatic logic ctrl_ovf(input logic [7:0] b);
        return (b == K_OVF) || (b == K_BC0_OVF);
    endfunction

endpackage

// File: rtl/trigger_link_rx_if.sv
// Decoded 8b/10b word stream from the trigger fiber transceiver.
interface trigger_link_rx_if;

    logic [15:0] rx_data;
    logic [1:0]  rx_charisk;
    logic        rx_err;
    logic        rx_valid;

    modport master (output rx_data, rx_charisk, rx_err, rx_valid);
    modport slave  (input  rx_data, rx_charisk, rx_err, rx_valid);

endinterface

// File: rtl/trigger_link_rx_aligner.sv
// Frame alignment for the trigger link: HUNT/VERIFY/LOCKED FSM, word index
// and per-frame good/bad evaluation.
module trigger_link_rx_aligner
    import trigger_link_pkg::*;
#(
    parameter int unsigned LOCK_GOOD  = 4,
    parameter int unsigned UNLOCK_BAD = 4
) (
    input  logic       clk_160,
    input  logic       reset_i,
    input  logic       rx_valid,
    input  logic [7:0] ctrl_byte,
    input  logic [1:0] rx_charisk,
    input  logic       rx_err,
    output logic [1:0] word_idx,
    output logic       frame_end,
    output logic       frame_good,
    output logic       locked,
    output logic       lost_lock
);

    localparam int unsigned GW = $clog2(LOCK_GOOD + 1);
    localparam int unsigned BW = $clog2(UNLOCK_BAD + 1);

    align_state_t  state_q, state_d;
    logic [1:0]    widx_q, widx_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic          first_q, first_d;
    logic          bad_q, bad_d;

    logic          ctrl_ok;
    logic          word_bad;
    logic          frame_bad;
    logic [GW-1:0] good_next;
    logic [BW-1:0] bad_next;

    // The frame that triggered VERIFY was already counted when its ctrl word
    // was found, so its own end must not count it a second time.
    always_comb begin
        ctrl_ok   = (rx_charisk == CHARISK_CTRL) && is_ctrl_byte(ctrl_byte) && !rx_err;
        word_bad  = (widx_q == 2'd0) ? !ctrl_ok : ((rx_charisk != 2'b00) || rx_err);
        frame_bad = bad_q || word_bad;
        good_next = first_q ? good_cnt_q : good_cnt_q + GW'(1);
        bad_next  = bad_cnt_q + BW'(1);
    end

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        first_d    = first_q;
        bad_d      = bad_q;
        frame_end  = 1'b0;
        frame_good = 1'b0;
        lost_lock  = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    widx_d = 2'd0;
                    if (ctrl_ok) begin
                        widx_d     = 2'd1;
                        good_cnt_d = GW'(1);
                        first_d    = 1'b1;
                        bad_d      = 1'b0;
                        state_d    = ST_VERIFY;
                    end
                end
                default: begin
                    widx_d = widx_q + 2'd1;
                    bad_d  = (widx_q == 2'd0) ? word_bad : frame_bad;
                    if (widx_q == LAST_WORD) begin
                        frame_end  = 1'b1;
                        frame_good = !frame_bad;
                        if (state_q == ST_VERIFY) begin
                            if (frame_bad) begin
                                state_d = ST_HUNT;
                                widx_d  = 2'd0;
                            end else begin
                                first_d    = 1'b0;
                                good_cnt_d = good_next;
                                if (good_next >= GW'(LOCK_GOOD)) begin
                                    state_d   = ST_LOCKED;
                                    bad_cnt_d = '0;
                                end
                            end
                        end else if (!frame_bad) begin
                            bad_cnt_d = '0;
                        end else if (bad_next >= BW'(UNLOCK_BAD)) begin
                            state_d   = ST_HUNT;
                            widx_d    = 2'd0;
                            bad_cnt_d = '0;
                            lost_lock = 1'b1;
                        end else begin
                            bad_cnt_d = bad_next;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_160) begin
        if (reset_i) begin
            state_q    <= ST_HUNT;
            widx_q     <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            first_q    <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            first_q    <= first_d;
            bad_q      <= bad_d;
        end
    end

    assign word_idx = widx_q;
    assign locked   = (state_q == ST_LOCKED);

endmodule

// File: rtl/trigger_link_rx.sv
// Trigger link receiver: frame capture, cluster decode, BX counter with BC0
// checking and saturating bad-frame counter around the frame aligner.
module trigger_link_rx
    import trigger_link_pkg::*;
#(
    parameter int unsigned NBX        = 3564,
    parameter int unsigned LOCK_GOOD  = 4,
    parameter int unsigned UNLOCK_BAD = 4
) (
    input  logic                  clk_160,
    input  logic                  reset_i,
    trigger_link_rx_if.slave      link,
    output logic [CLUSTER_W-1:0]  cluster0,
    output logic [CLUSTER_W-1:0]  cluster1,
    output logic [CLUSTER_W-1:0]  cluster2,
    output logic [CLUSTER_W-1:0]  cluster3,
    output logic                  frame_valid,
    output logic                  bc0,
    output logic                  overflow,
    output logic [N_CLUSTERS-1:0] valid_clusters,
    output logic                  locked,
    output logic [11:0]           bx_cnt,
    output logic                  bc0_err,
    output logic [15:0]           err_cnt
);

    localparam int unsigned HEAD_BITS = FRAME_BITS - 16;

    logic [1:0] word_idx;
    logic       frame_end;
    logic       frame_good;
    logic       aligned;
    logic       lost_lock;

    trigger_link_rx_aligner #(
        .LOCK_GOOD  (LOCK_GOOD),
        .UNLOCK_BAD (UNLOCK_BAD)
    ) u_aligner (
        .clk_160    (clk_160),
        .reset_i    (reset_i),
        .rx_valid   (link.rx_valid),
        .ctrl_byte  (link.rx_data[15:8]),
        .rx_charisk (link.rx_charisk),
        .rx_err     (link.rx_err),
        .word_idx   (word_idx),
        .frame_end  (frame_end),
        .frame_good (frame_good),
        .locked     (aligned),
        .lost_lock  (lost_lock)
    );

    logic [7:0]                          ctrl_q, ctrl_d;
    logic [HEAD_BITS-1:0]                head_q, head_d;
    logic [FRAME_BITS-1:0]               frame_data;
    logic [N_CLUSTERS-1:0][CLUSTER_W-1:0] cl_q, cl_d;
    logic                                fv_q, fv_d;
    logic                                bc0_q, bc0_d;
    logic                                ovf_q, ovf_d;
    logic [N_CLUSTERS-1:0]               vc_q, vc_d;
    logic                                bc0_err_q, bc0_err_d;
    logic                                synced_q, synced_d;
    logic [11:0]                         bx_q, bx_d, bx_nxt;
    logic [15:0]                         err_q, err_d;

    // Words 0..2 are buffered; word 3 is combined live on the frame-end cycle.
    always_comb begin
        ctrl_d = ctrl_q;
        head_d = head_q;
        if (link.rx_valid) begin
            case (word_idx)
                2'd0: begin
                    ctrl_d       = link.rx_data[15:8];
                    head_d[7:0]  = link.rx_data[7:0];
                end
                2'd1:    head_d[23:8]  = link.rx_data;
                2'd2:    head_d[39:24] = link.rx_data;
                default: ;
            endcase
        end
    end

    assign frame_data = {link.rx_data, head_q};

    always_comb begin
        cl_d      = cl_q;
        fv_d      = 1'b0;
        bc0_d     = 1'b0;
        ovf_d     = 1'b0;
        vc_d      = '0;
        bc0_err_d = 1'b0;
        bx_d      = bx_q;
        synced_d  = synced_q;
        err_d     = err_q;
        bx_nxt    = (bx_q == 12'(NBX - 1)) ? '0 : bx_q + 12'd1;
        if (frame_end && aligned) begin
            if (frame_good) begin
                cl_d  = frame_data;
                fv_d  = 1'b1;
                bc0_d = ctrl_bc0(ctrl_q);
                ovf_d = ctrl_ovf(ctrl_q);
                for (int unsigned n = 0; n < N_CLUSTERS; n++) begin
                    vc_d[n] = (cl_d[n][10:9] != 2'b11);
                end
                if (ctrl_bc0(ctrl_q)) begin
                    bx_d      = '0;
                    synced_d  = 1'b1;
                    bc0_err_d = synced_q && (bx_nxt != '0);
                end else begin
                    bx_d = bx_nxt;
                end
            end else begin
                bx_d = bx_nxt;
                if (err_q != '1) begin
                    err_d = err_q + 16'd1;
                end
            end
        end
        if (lost_lock) begin
            synced_d = 1'b0;
        end
    end

    always_ff @(posedge clk_160) begin
        if (reset_i) begin
            ctrl_q    <= '0;
            head_q    <= '0;
            cl_q      <= '0;
            fv_q      <= 1'b0;
            bc0_q     <= 1'b0;
            ovf_q     <= 1'b0;
            vc_q      <= '0;
            bc0_err_q <= 1'b0;
            synced_q  <= 1'b0;
            bx_q      <= '0;
            err_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            head_q    <= head_d;
            cl_q      <= cl_d;
            fv_q      <= fv_d;
            bc0_q     <= bc0_d;
            ovf_q     <= ovf_d;
            vc_q      <= vc_d;
            bc0_err_q <= bc0_err_d;
            synced_q  <= synced_d;
            bx_q      <= bx_d;
            err_q     <= err_d;
        end
    end

    assign cluster0       = cl_q[0];
    assign cluster1       = cl_q[1];
    assign cluster2       = cl_q[2];
    assign cluster3       = cl_q[3];
    assign frame_valid    = fv_q;
    assign bc0            = bc0_q;
    assign overflow       = ovf_q;
    assign valid_clusters = vc_q;
    assign locked         = aligned;
    assign bx_cnt         = bx_q;
    assign bc0_err        = bc0_err_q;
    assign err_cnt        = err_q;

endmodule

// File: tb/tb_trigger_link_rx.sv
// Directed bench for trigger_link_rx: lock-up, cluster decode, BX/BC0
// tracking, bad-frame handling, misaligned/gapped stream and mid-frame reset.
module tb_trigger_link_rx;

    logic        clk_160 = 1'b0;
    logic        reset_i;
    logic [13:0] cluster0, cluster1, cluster2, cluster3;
    logic        frame_valid, bc0, overflow, locked, bc0_err;
    logic [3:0]  valid_clusters;
    logic [11:0] bx_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit gap_mode = 1'b0;

    trigger_link_rx_if link();

    trigger_link_rx #(
        .NBX        (3564),
        .LOCK_GOOD  (4),
        .UNLOCK_BAD (4)
    ) dut (
        .clk_160        (clk_160),
        .reset_i        (reset_i),
        .link           (link),
        .cluster0       (cluster0),
        .cluster1       (cluster1),
        .cluster2       (cluster2),
        .cluster3       (cluster3),
        .frame_valid    (frame_valid),
        .bc0            (bc0),
        .overflow       (overflow),
        .valid_clusters (valid_clusters),
        .locked         (locked),
        .bx_cnt         (bx_cnt),
        .bc0_err        (bc0_err),
        .err_cnt        (err_cnt)
    );

    always #3 clk_160 = ~clk_160;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cl0"}, cluster0, 0);
        chk({tag, "_cl1"}, cluster1, 0);
        chk({tag, "_cl2"}, cluster2, 0);
        chk({tag, "_cl3"}, cluster3, 0);
        chk({tag, "_fv"}, frame_valid, 0);
        chk({tag, "_bc0"}, bc0, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_vc"}, valid_clusters, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_bx"}, bx_cnt, 0);
        chk({tag, "_bc0err"}, bc0_err, 0);
        chk({tag, "_errcnt"}, err_cnt, 0);
    endtask

    // In gap mode every word is preceded by an ignored cycle that carries a
    // perfect-looking ctrl word, so it must have no effect at all.
    task automatic send_word(input logic [15:0] d, input logic [1:0] k, input logic e);
        if (gap_mode) begin
            link.rx_valid   = 1'b0;
            link.rx_data    = 16'hBCA5;
            link.rx_charisk = 2'b10;
            link.rx_err     = 1'b0;
            @(posedge clk_160);
            #1;
        end
        link.rx_valid   = 1'b1;
        link.rx_data    = d;
        link.rx_charisk = k;
        link.rx_err     = e;
        @(posedge clk_160);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] ctrl, input logic [55:0] d,
                              input logic [3:0] errw, input logic [3:0] kbad);
        send_word({ctrl, d[7:0]}, {1'b1, kbad[0]}, errw[0]);
        send_word(d[23:8],  {1'b0, kbad[1]}, errw[1]);
        send_word(d[39:24], {1'b0, kbad[2]}, errw[2]);
        send_word(d[55:40], {1'b0, kbad[3]}, errw[3]);
    endtask

    initial begin
        reset_i         = 1'b1;
        link.rx_valid   = 1'b0;
        link.rx_data    = 16'h0000;
        link.rx_charisk = 2'b00;
        link.rx_err     = 1'b0;
        repeat (2) @(posedge clk_160);
        #1;
        chk_all_zero("reset");
        reset_i = 1'b0;

        // Lock-up: four clean frames, first strobe on frame five.
        for (int f = 1; f <= 4; f++) begin
            send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
            if (f == 3) chk("lock_f3", locked, 0);
        end
        chk("lock_f4", locked, 1);
        chk("fv_f4", frame_valid, 0);
        send_frame(8'hBC, 56'h0C0A5123456789, 4'b0000, 4'b0000);
        chk("fv_f5", frame_valid, 1);
        chk("dec_cl0", cluster0, 14'h2789);
        chk("dec_cl1", cluster1, 14'h0D15);
        chk("dec_cl2", cluster2, 14'h2512);
        chk("dec_cl3", cluster3, 14'h0302);
        chk("dec_vc", valid_clusters, 4'b1110);
        chk("dec_bc0", bc0, 0);
        chk("dec_bx", bx_cnt, 1);

        // Overflow frame, written out word by word to catch the strobe ending.
        send_word(16'h7C00, 2'b10, 1'b0);
        chk("fv_strobe", frame_valid, 0);
        chk("cl0_hold", cluster0, 14'h2789);
        send_word(16'h0000, 2'b00, 1'b0);
        send_word(16'h0000, 2'b00, 1'b0);
        send_word(16'h0000, 2'b00, 1'b0);
        chk("ovf_fv", frame_valid, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_bc0", bc0, 0);
        chk("ovf_vc", valid_clusters, 4'b1111);
        chk("ovf_cl0", cluster0, 0);
        chk("ovf_bx", bx_cnt, 2);

        // BX tracking across a full orbit and a short orbit.
        send_frame(8'h3C, 56'h0, 4'b0000, 4'b0000);
        chk("bc0a_bx", bx_cnt, 0);
        chk("bc0a_flag", bc0, 1);
        chk("bc0a_err", bc0_err, 0);
        repeat (3563) send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
        chk("orbit_end_bx", bx_cnt, 3563);
        send_frame(8'hFC, 56'h0, 4'b0000, 4'b0000);
        chk("bc0b_bx", bx_cnt, 0);
        chk("bc0b_err", bc0_err, 0);
        chk("bc0b_ovf", overflow, 1);
        repeat (2999) send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
        chk("short_bx", bx_cnt, 2999);
        send_frame(8'h3C, 56'h0, 4'b0000, 4'b0000);
        chk("bc0c_err", bc0_err, 1);
        chk("bc0c_bx", bx_cnt, 0);
        send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
        chk("bc0c_err_clr", bc0_err, 0);
        chk("after_bx", bx_cnt, 1);
        repeat (3562) send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
        chk("wrap_pre_bx", bx_cnt, 3563);
        send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
        chk("wrap_bx", bx_cnt, 0);

        // Bad frames while locked.
        chk("err_init", err_cnt, 0);
        send_frame(8'hBC, 56'h1ABC, 4'b0000, 4'b0000);
        chk("good_cl0", cluster0, 14'h1ABC);
        chk("good_vc", valid_clusters, 4'b1111);
        for (int b = 0; b < 3; b++) begin
            send_frame(8'h3C, 56'hFFFFFFFFFFFFFF, 4'b0100, 4'b0000);
            chk("bad_fv", frame_valid, 0);
            chk("bad_locked", locked, 1);
        end
        chk("bad3_err", err_cnt, 3);
        chk("bad3_cl0_hold", cluster0, 14'h1ABC);
        chk("bad3_bc0", bc0, 0);
        chk("bad3_vc", valid_clusters, 0);
        chk("bad3_bx", bx_cnt, 4);
        send_frame(8'hBC, 56'h1ABC, 4'b0000, 4'b0000);
        chk("recov_locked", locked, 1);
        chk("recov_fv", frame_valid, 1);
        chk("recov_err", err_cnt, 3);
        chk("recov_bx", bx_cnt, 5);
        send_frame(8'hBC, 56'h0, 4'b0000, 4'b0010);
        send_frame(8'h5C, 56'h0, 4'b0000, 4'b0000);
        send_frame(8'hBC, 56'h0, 4'b0001, 4'b0000);
        chk("bad7_locked", locked, 1);
        chk("bad7_err", err_cnt, 6);
        send_frame(8'hBC, 56'h0, 4'b1000, 4'b0000);
        chk("unlock_locked", locked, 0);
        chk("unlock_err", err_cnt, 7);
        chk("unlock_cl0_hold", cluster0, 14'h1ABC);
        chk("unlock_fv", frame_valid, 0);

        // Stream entering mid-frame, with rx_valid toggling every cycle.
        reset_i = 1'b1;
        @(posedge clk_160);
        #1;
        reset_i = 1'b0;
        chk("rst2_err", err_cnt, 0);
        chk("rst2_locked", locked, 0);
        gap_mode = 1'b1;
        send_word(16'h1234, 2'b00, 1'b0);
        send_word(16'h5678, 2'b00, 1'b0);
        for (int f = 1; f <= 4; f++) begin
            send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
            if (f == 3) chk("gap_lock_f3", locked, 0);
        end
        chk("gap_lock_f4", locked, 1);
        send_frame(8'hBC, {14'h3FFF, 14'h0000, 14'h2AAA, 14'h1555}, 4'b0000, 4'b0000);
        chk("gap_fv", frame_valid, 1);
        chk("gap_cl0", cluster0, 14'h1555);
        chk("gap_cl1", cluster1, 14'h2AAA);
        chk("gap_cl2", cluster2, 14'h0000);
        chk("gap_cl3", cluster3, 14'h3FFF);
        chk("gap_vc", valid_clusters, 4'b0111);
        chk("gap_err", err_cnt, 0);
        chk("gap_bx", bx_cnt, 1);
        link.rx_valid = 1'b0;
        @(posedge clk_160);
        #1;
        chk("gap_fv_strobe", frame_valid, 0);
        gap_mode = 1'b0;

        // Reset during word 2 of a locked frame.
        send_word(16'hBC11, 2'b10, 1'b0);
        send_word(16'h2222, 2'b00, 1'b0);
        reset_i = 1'b1;
        send_word(16'h3333, 2'b00, 1'b0);
        reset_i = 1'b0;
        chk_all_zero("rst_mid");
        send_word(16'h4444, 2'b00, 1'b0);
        chk("rst_mid_w3_fv", frame_valid, 0);
        for (int f = 1; f <= 4; f++) begin
            send_frame(8'hBC, 56'h0, 4'b0000, 4'b0000);
            if (f == 3) chk("relock_f3", locked, 0);
        end
        chk("relock_f4", locked, 1);
        send_frame(8'hBC, 56'h0C0A5123456789, 4'b0000, 4'b0000);
        chk("relock_fv", frame_valid, 1);
        chk("relock_cl0", cluster0, 14'h2789);
        link.rx_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
